// File: rtl/connect4_turn_controller.sv
// Connect-4 turn sequencer: accepts column moves, drops pieces into the lowest
// free row, hands the board to the win detector, and alternates players or ends
// the game on win, draw or full board. Owns the board registers.
module connect4_turn_controller #(
    parameter int COLS          = 4,
    parameter int ROWS          = 4,
    parameter int COL_W         = 4,
    parameter int CHECK_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 move_req,
    input  logic [COL_W-1:0]     move_col,
    input  logic                 new_game,
    input  logic                 check_done,
    input  logic [1:0]           check_result,
    output logic                 check_start,
    output logic [COLS*ROWS-1:0] gameboard_out,
    output logic [COLS*ROWS-1:0] player_cells,
    output logic                 current_player,
    output logic [1:0]           game_status,
    output logic                 move_ack,
    output logic                 move_reject
);

    localparam int CELLS  = COLS * ROWS;
    localparam int CIDX_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int HGT_W  = $clog2(ROWS + 1);
    localparam int IDX_W  = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int CNT_W  = $clog2(CELLS + 1);
    localparam int TMR_W  = $clog2(CHECK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        WAIT_MOVE,
        PLACE,
        CHECK,
        WAIT_CHECK,
        GAME_OVER
    } state_t;

    state_t            state;
    logic [HGT_W-1:0]  heights [COLS];
    logic [CNT_W-1:0]  move_count;
    logic [CIDX_W-1:0] col_q;
    logic [TMR_W-1:0]  timer;

    logic [CIDX_W-1:0] req_idx;
    logic              col_in_range;
    logic              col_full;
    logic [IDX_W-1:0]  place_idx;
    logic              resolve;
    logic [1:0]        eff_result;
    logic              is_win;

    // Decode the requested column, the drop cell and the check outcome
    always_comb begin
        req_idx      = move_col[CIDX_W-1:0];
        col_in_range = (move_col < COL_W'(COLS));
        col_full     = (heights[req_idx] == HGT_W'(ROWS));
        place_idx    = IDX_W'(heights[col_q]) * IDX_W'(COLS) + IDX_W'(col_q);
        // A timeout is resolved exactly like a "no win" answer
        resolve      = check_done || (timer >= TMR_W'(CHECK_TIMEOUT - 1));
        eff_result   = check_done ? check_result : 2'b00;
        is_win       = (eff_result == 2'b01) || (eff_result == 2'b10);
    end

    // Game FSM with registered outputs; new_game clears exactly like reset
    always_ff @(posedge clk) begin
        if (reset || new_game) begin
            state          <= WAIT_MOVE;
            for (int unsigned i = 0; i < COLS; i++) heights[i] <= '0;
            move_count     <= '0;
            col_q          <= '0;
            timer          <= '0;
            check_start    <= 1'b0;
            gameboard_out  <= '0;
            player_cells   <= '0;
            current_player <= 1'b0;
            game_status    <= 2'b00;
            move_ack       <= 1'b0;
            move_reject    <= 1'b0;
        end else begin
            check_start <= 1'b0;
            move_ack    <= 1'b0;
            move_reject <= 1'b0;
            case (state)
                WAIT_MOVE: begin
                    if (move_req) begin
                        if (!col_in_range || col_full) begin
                            move_reject <= 1'b1;
                        end else begin
                            col_q <= req_idx;
                            state <= PLACE;
                        end
                    end
                end
                PLACE: begin
                    gameboard_out[place_idx] <= 1'b1;
                    player_cells[place_idx]  <= current_player;
                    heights[col_q]           <= heights[col_q] + 1'b1;
                    move_count               <= move_count + 1'b1;
                    check_start              <= 1'b1;
                    state                    <= CHECK;
                end
                CHECK: begin
                    timer <= TMR_W'(1);
                    state <= WAIT_CHECK;
                end
                WAIT_CHECK: begin
                    if (resolve) begin
                        if (is_win) begin
                            game_status <= eff_result;
                            state       <= GAME_OVER;
                        end else if (move_count == CNT_W'(CELLS)) begin
                            game_status <= 2'b11;
                            state       <= GAME_OVER;
                        end else begin
                            current_player <= ~current_player;
                            move_ack       <= 1'b1;
                            state          <= WAIT_MOVE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                GAME_OVER: begin
                    state <= GAME_OVER;
                end
                default: state <= WAIT_MOVE;
            endcase
        end
    end

endmodule

// File: tb/tb_connect4_turn_controller.sv
// Testbench for connect4_turn_controller: directed scenarios plus randomized
// games checked against a board-level reference model.
module tb_connect4_turn_controller;

    localparam int COLS          = 4;
    localparam int ROWS          = 4;
    localparam int COL_W         = 4;
    localparam int CHECK_TIMEOUT = 15;
    localparam int CELLS         = COLS * ROWS;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 move_req;
    logic [COL_W-1:0]     move_col;
    logic                 new_game;
    logic                 check_done;
    logic [1:0]           check_result;
    logic                 check_start;
    logic [CELLS-1:0]     gameboard_out;
    logic [CELLS-1:0]     player_cells;
    logic                 current_player;
    logic [1:0]           game_status;
    logic                 move_ack;
    logic                 move_reject;

    int checks = 0;
    int errors = 0;

    // Reference model: owner of every cell (-1 empty), plus game bookkeeping
    int m_owner [COLS][ROWS];
    int m_player;
    int m_status;
    int m_count;

    connect4_turn_controller #(
        .COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .CHECK_TIMEOUT(CHECK_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .move_req(move_req), .move_col(move_col),
        .new_game(new_game), .check_done(check_done), .check_result(check_result),
        .check_start(check_start), .gameboard_out(gameboard_out),
        .player_cells(player_cells), .current_player(current_player),
        .game_status(game_status), .move_ack(move_ack), .move_reject(move_reject)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock edge; drive and sample 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int m_height(input int c);
        int h = 0;
        for (int r = 0; r < ROWS; r++) if (m_owner[c][r] >= 0) h++;
        return h;
    endfunction

    function automatic logic [CELLS-1:0] m_board();
        logic [CELLS-1:0] b = '0;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                if (m_owner[c][r] >= 0) b[r*COLS + c] = 1'b1;
        return b;
    endfunction

    function automatic logic [CELLS-1:0] m_cells();
        logic [CELLS-1:0] b = '0;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                if (m_owner[c][r] == 1) b[r*COLS + c] = 1'b1;
        return b;
    endfunction

    task automatic m_clear();
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++) m_owner[c][r] = -1;
        m_player = 0;
        m_status = 0;
        m_count  = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_board"},  32'(gameboard_out),  32'(m_board()));
        check({tag, "_cells"},  32'(player_cells),   32'(m_cells()));
        check({tag, "_player"}, 32'(current_player), 32'(m_player));
        check({tag, "_status"}, 32'(game_status),    32'(m_status));
    endtask

    task automatic check_idle(input string tag);
        check_all(tag);
        check({tag, "_start"},  32'(check_start), 0);
        check({tag, "_ack"},    32'(move_ack),    0);
        check({tag, "_reject"}, 32'(move_reject), 0);
    endtask

    task automatic do_new_game();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        m_clear();
        check_idle("newgame");
    endtask

    // One move request; k = cycle after check_start carrying check_done (0 = withheld)
    task automatic do_move(input int col, input logic [1:0] res, input int k);
        int h;
        int eff;
        move_col = COL_W'(col);
        move_req = 1'b1;
        tick();
        move_req = 1'b0;
        if (m_status != 0) begin
            check("over_reject", 32'(move_reject), 0);
            tick();
            check("over_start", 32'(check_start), 0);
            tick();
            check_idle("over");
            return;
        end
        if (col >= COLS || m_height(col) == ROWS) begin
            check("reject", 32'(move_reject), 1);
            check_all("reject");
            tick();
            check("reject_pulse", 32'(move_reject), 0);
            check_all("reject_after");
            return;
        end
        check("place_start", 32'(check_start), 0);
        check("place_board_old", 32'(gameboard_out), 32'(m_board()));
        h = m_height(col);
        m_owner[col][h] = m_player;
        m_count++;
        tick();
        check("check_start", 32'(check_start), 1);
        check_all("placed");
        tick();
        check("start_pulse", 32'(check_start), 0);
        if (k > 0) begin
            for (int i = 1; i < k; i++) begin
                check("ack_early", 32'(move_ack), 0);
                tick();
            end
            check_done   = 1'b1;
            check_result = res;
            tick();
            check_done   = 1'b0;
            check_result = 2'b00;
            eff = int'(res);
        end else begin
            for (int i = 1; i < CHECK_TIMEOUT; i++) begin
                check("ack_early_to", 32'(move_ack), 0);
                tick();
            end
            eff = 0;
        end
        if (eff == 1 || eff == 2) begin
            m_status = eff;
            check("ack_win", 32'(move_ack), 0);
        end else if (m_count == CELLS) begin
            m_status = 3;
            check("ack_draw", 32'(move_ack), 0);
        end else begin
            m_player ^= 1;
            check("ack", 32'(move_ack), 1);
        end
        check_all("resolved");
        tick();
        check("ack_pulse", 32'(move_ack), 0);
        check_all("settled");
    endtask

    initial begin
        int k;
        logic [1:0] res;
        reset = 1'b1; move_req = 1'b0; move_col = '0; new_game = 1'b0;
        check_done = 1'b0; check_result = 2'b00;
        m_clear();
        tick();
        tick();
        check_idle("reset");
        reset = 1'b0;
        tick();
        check_idle("post_reset");

        // First move into column 0
        do_move(0, 2'b00, 1);
        check("first_board", 32'(gameboard_out), 32'h0001);

        // Fill column 2 and overflow it
        do_new_game();
        for (int i = 0; i < ROWS; i++) do_move(2, 2'b00, 3);
        do_move(2, 2'b00, 1);

        // Out-of-range column, then a valid edge column
        do_new_game();
        do_move(5, 2'b00, 1);
        do_move(15, 2'b00, 1);
        do_move(3, 2'b00, 2);
        check("col3_board", 32'(gameboard_out), 32'h0008);

        // Win reported on move 7, later requests ignored, then new game
        do_new_game();
        for (int i = 0; i < 6; i++) do_move(i % COLS, 2'b00, 1);
        do_move(1, 2'b01, 4);
        check("win_status", 32'(game_status), 1);
        do_move(2, 2'b00, 1);
        do_move(7, 2'b00, 1);
        do_new_game();

        // Result 11 treated as no win; full board becomes a draw
        for (int i = 0; i < CELLS; i++)
            do_move(i / ROWS, (i % 3 == 0) ? 2'b11 : 2'b00, 1 + (i % 14));
        check("draw_status", 32'(game_status), 3);
        do_new_game();

        // Withheld check_done: timeout path
        do_move(1, 2'b00, 0);
        do_move(1, 2'b00, 0);

        // Reset inside WAIT_CHECK
        move_col = COL_W'(0); move_req = 1'b1; tick(); move_req = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        m_clear();
        check_idle("reset_midcheck");

        // new_game inside WAIT_CHECK; a late win answer must be ignored
        do_move(2, 2'b00, 1);
        move_col = COL_W'(1); move_req = 1'b1; tick(); move_req = 1'b0;
        tick(); tick();
        new_game = 1'b1; tick(); new_game = 1'b0;
        m_clear();
        check_done = 1'b1; check_result = 2'b10; tick();
        check_done = 1'b0; check_result = 2'b00;
        check_idle("ng_midcheck");
        tick();
        check_idle("ng_midcheck2");

        // Randomized games
        for (int g = 0; g < 12; g++) begin
            for (int m = 0; m < 26; m++) begin
                k = int'($urandom_range(0, 14));
                case ($urandom_range(0, 19))
                    0:       res = 2'b01;
                    1:       res = 2'b10;
                    2, 3:    res = 2'b11;
                    default: res = 2'b00;
                endcase
                do_move(int'($urandom_range(0, 5)), res, k);
            end
            do_new_game();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
